// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared command/state encodings and word-size helper for the
//               single-word DRAM<->SRAM DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_D2S  = 2'b01,
        CMD_S2D  = 2'b10,
        CMD_RSVD = 2'b11
    } dma_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D2S_RD  = 3'd1,
        ST_D2S_WR  = 3'd2,
        ST_S2D_SRD = 3'd3,
        ST_S2D_CAP = 3'd4,
        ST_S2D_WR  = 3'd5,
        ST_DONE    = 3'd6
    } dma_state_e;

    function automatic int unsigned word_bytes(input int unsigned dw);
        return dw / 8;
    endfunction

    localparam int unsigned WORD_BYTES = DEF_DATA_W / 8;

endpackage
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : dma_addr_gen
// Description : Current source/destination byte addresses and remaining word
//               count; load on accept, step after each completed write.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned STEP_BYTES = WORD_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic [31:0]      o_src,
    output logic [31:0]      o_dst,
    output logic             o_last
);

    localparam logic [31:0] c_STEP = 32'(STEP_BYTES);

    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_rest;

    // 32-bit adders wrap naturally; the SRAM side only uses the low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rest <= '0;
        end else if (i_load) begin
            r_src  <= i_src;
            r_dst  <= i_dst;
            r_rest <= i_len;
        end else if (i_step) begin
            r_src  <= r_src + c_STEP;
            r_dst  <= r_dst + c_STEP;
            r_rest <= r_rest - LEN_W'(1);
        end
    end

    assign o_src  = r_src;
    assign o_dst  = r_dst;
    assign o_last = (r_rest == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_engine
// Description : Single-word DMA between DRAM (request/valid port) and
//               synchronous SRAM. SRAM->DRAM path built only with DMA_S2D_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned LEN_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cmd,
    input  logic [31:0]        srcAddr,
    input  logic [31:0]        destAddr,
    input  logic [LEN_W-1:0]   len,
    input  logic [DATA_W-1:0]  sramReadData,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic [DATA_W-1:0]  sramWriteData,
    output logic               sramWriteEnable,
    output logic [31:0]        dramAddress,
    output logic [DATA_W-1:0]  dramWriteData,
    output logic               dramReadEnable,
    output logic               dramWriteEnable,
    input  logic [DATA_W-1:0]  dramReadData,
    input  logic               dramValid,
    output logic               stall,
    output logic               dmaValid
);

    localparam logic [2:0] c_IDLE    = ST_IDLE;
    localparam logic [2:0] c_D2S_RD  = ST_D2S_RD;
    localparam logic [2:0] c_D2S_WR  = ST_D2S_WR;
`ifdef DMA_S2D_EN
    localparam logic [2:0] c_S2D_SRD = ST_S2D_SRD;
    localparam logic [2:0] c_S2D_CAP = ST_S2D_CAP;
    localparam logic [2:0] c_S2D_WR  = ST_S2D_WR;
`endif
    localparam logic [2:0] c_DONE    = ST_DONE;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       w_cur_src;
    logic [31:0]       w_cur_dst;
    logic              w_last;
    logic              w_cmd_d2s;
    logic              w_cmd_s2d;
    logic              w_accept;
    logic              w_step;

    assign w_cmd_d2s = (cmd == CMD_D2S);
`ifdef DMA_S2D_EN
    assign w_cmd_s2d = (cmd == CMD_S2D);
    assign w_step    = (r_state == c_D2S_WR) | ((r_state == c_S2D_WR) & dramValid);
`else
    assign w_cmd_s2d = 1'b0;
    assign w_step    = (r_state == c_D2S_WR);
`endif
    assign w_accept  = (r_state == c_IDLE) & (w_cmd_d2s | w_cmd_s2d);

    dma_addr_gen #(
        .LEN_W      (LEN_W),
        .STEP_BYTES (word_bytes(DATA_W))
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (w_step),
        .i_src  (srcAddr),
        .i_dst  (destAddr),
        .i_len  (len),
        .o_src  (w_cur_src),
        .o_dst  (w_cur_dst),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (len == '0)
                        w_state_nxt = c_DONE;
                    else if (w_cmd_d2s)
                        w_state_nxt = c_D2S_RD;
`ifdef DMA_S2D_EN
                    else
                        w_state_nxt = c_S2D_SRD;
`endif
                end
            end
            c_D2S_RD:  if (dramValid) w_state_nxt = c_D2S_WR;
            c_D2S_WR:  w_state_nxt = w_last ? c_DONE : c_D2S_RD;
`ifdef DMA_S2D_EN
            c_S2D_SRD: w_state_nxt = c_S2D_CAP;
            c_S2D_CAP: w_state_nxt = c_S2D_WR;
            c_S2D_WR:  if (dramValid) w_state_nxt = w_last ? c_DONE : c_S2D_SRD;
`endif
            c_DONE:    w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Single holding register serves both directions; only one is ever live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_data <= '0;
        else if ((r_state == c_D2S_RD) && dramValid)
            r_data <= dramReadData;
`ifdef DMA_S2D_EN
        else if (r_state == c_S2D_CAP)
            r_data <= sramReadData;
`endif
    end

    always_comb begin
        sramAddress     = '0;
        sramWriteData   = '0;
        sramWriteEnable = 1'b0;
        dramAddress     = '0;
        dramWriteData   = '0;
        dramReadEnable  = 1'b0;
        dramWriteEnable = 1'b0;
        case (r_state)
            c_D2S_RD: begin
                dramReadEnable = 1'b1;
                dramAddress    = w_cur_src;
            end
            c_D2S_WR: begin
                sramWriteEnable = 1'b1;
                sramAddress     = w_cur_dst[SRAM_AW-1:0];
                sramWriteData   = r_data;
            end
`ifdef DMA_S2D_EN
            c_S2D_SRD: begin
                sramAddress = w_cur_src[SRAM_AW-1:0];
            end
            c_S2D_WR: begin
                dramWriteEnable = 1'b1;
                dramAddress     = w_cur_dst;
                dramWriteData   = r_data;
            end
`endif
            default: ;
        endcase
    end

    assign stall    = ((r_state != c_IDLE) && (r_state != c_DONE)) | w_accept;
    assign dmaValid = (r_state == c_DONE);

`ifndef DMA_S2D_EN
    logic w_unused;
    assign w_unused = ^{w_cur_dst[31:SRAM_AW], sramReadData};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_engine
// Description : Self-checking bench for dma_engine: directed table, reset and
//               busy-command sequences, then randomized transfers vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_engine;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SRAM_AW = 14;
    localparam int unsigned LEN_W   = 10;
`ifdef DMA_S2D_EN
    localparam bit S2D = 1'b1;
`else
    localparam bit S2D = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         cmd;
    logic [31:0]        srcAddr;
    logic [31:0]        destAddr;
    logic [LEN_W-1:0]   len;
    logic [DATA_W-1:0]  sramReadData;
    logic [SRAM_AW-1:0] sramAddress;
    logic [DATA_W-1:0]  sramWriteData;
    logic               sramWriteEnable;
    logic [31:0]        dramAddress;
    logic [DATA_W-1:0]  dramWriteData;
    logic               dramReadEnable;
    logic               dramWriteEnable;
    logic [DATA_W-1:0]  dramReadData;
    logic               dramValid;
    logic               stall;
    logic               dmaValid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_engine #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd             (cmd),
        .srcAddr         (srcAddr),
        .destAddr        (destAddr),
        .len             (len),
        .sramReadData    (sramReadData),
        .sramAddress     (sramAddress),
        .sramWriteData   (sramWriteData),
        .sramWriteEnable (sramWriteEnable),
        .dramAddress     (dramAddress),
        .dramWriteData   (dramWriteData),
        .dramReadEnable  (dramReadEnable),
        .dramWriteEnable (dramWriteEnable),
        .dramReadData    (dramReadData),
        .dramValid       (dramValid),
        .stall           (stall),
        .dmaValid        (dmaValid)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] dram_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] sram_init(input int unsigned i);
        return (i * 32'h0100_0193) + 32'hC0DE_0000;
    endfunction

    logic [31:0] sram_wr [int unsigned];

    function automatic logic [31:0] sram_peek(input logic [31:0] byte_addr);
        int unsigned idx;
        idx = int'(byte_addr[SRAM_AW-1:2]);
        return sram_wr.exists(idx) ? sram_wr[idx] : sram_init(idx);
    endfunction

    always @(posedge clk) begin
        if (sramWriteEnable)
            sram_wr[int'(sramAddress[SRAM_AW-1:2])] = sramWriteData;
        sramReadData <= sram_peek(32'(sramAddress));
    end

    int unsigned wcnt = 0;
    int unsigned cur_wait = 0;
    int unsigned fixed_wait;
    bit          rand_wait;
    bit          stray;
    int          wait_q[$];

    assign dramValid    = ((dramReadEnable | dramWriteEnable) && (wcnt == cur_wait)) || stray;
    assign dramReadData = dram_val(dramAddress);

    // Wait count is chosen while no request is open and held for the request.
    always @(posedge clk) begin
        if (dramReadEnable | dramWriteEnable) begin
            if (wcnt == cur_wait) begin
                wait_q.push_back(int'(cur_wait));
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt     <= 0;
            cur_wait <= rand_wait ? $urandom_range(0, 3) : fixed_wait;
        end
    end

    // ---------------- bus monitor ----------------
    logic [31:0] sw_a[$], sw_d[$], dw_a[$], dw_d[$];
    int dre_cyc = 0, dwe_cyc = 0, valid_cnt = 0, overlap_cnt = 0;

    always @(negedge clk) begin
        if (sramWriteEnable) begin
            sw_a.push_back(32'(sramAddress));
            sw_d.push_back(sramWriteData);
        end
        if (dramWriteEnable && dramValid) begin
            dw_a.push_back(dramAddress);
            dw_d.push_back(dramWriteData);
        end
        dre_cyc += int'(dramReadEnable);
        dwe_cyc += int'(dramWriteEnable);
        if (dmaValid) valid_cnt++;
        if ((sramWriteEnable && (dramReadEnable || dramWriteEnable)) ||
            (dramReadEnable && dramWriteEnable))
            overlap_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One transfer: drive, wait for completion (bounded), compare with model.
    task automatic xfer(input string nm, input logic [1:0] c, input logic [31:0] s,
                        input logic [31:0] d, input logic [LEN_W-1:0] n, input bit rw,
                        input int unsigned w, input logic [1:0] inj, input int exp_edges);
        bit acc, d2s, sacc, seen;
        int sw0, dw0, wq0, vc0, dre0, dwe0, edges, budget, sumw, nw, e_exp;
        acc    = (c == 2'b01) || ((c == 2'b10) && S2D);
        d2s    = (c == 2'b01);
        budget = acc ? 100 : 12;
        sw0 = sw_a.size(); dw0 = dw_a.size(); wq0 = wait_q.size();
        vc0 = valid_cnt; dre0 = dre_cyc; dwe0 = dwe_cyc;
        rand_wait = rw; fixed_wait = w; stray = !acc;
        @(negedge clk);
        cmd = c; srcAddr = s; destAddr = d; len = n;
        #1 sacc = stall;
        edges = 0; seen = 1'b0;
        while (!seen && edges < budget) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            cmd      = (edges == 2) ? inj : 2'b00;
            srcAddr  = $urandom;
            destAddr = $urandom;
            len      = LEN_W'($urandom);
            if (dmaValid) begin
                seen = 1'b1;
                chk({nm, "_stall_at_done"}, 64'(stall), 64'd0);
            end
        end
        cmd = 2'b00; stray = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk({nm, "_stall_accept"}, 64'(sacc), 64'(acc));
        chk({nm, "_valid_pulses"}, 64'(valid_cnt - vc0), acc ? 64'd1 : 64'd0);
        nw = acc ? int'(n) : 0;
        chk({nm, "_sram_writes"}, 64'(sw_a.size() - sw0), (acc && d2s) ? 64'(nw) : 64'd0);
        chk({nm, "_dram_writes"}, 64'(dw_a.size() - dw0), (acc && !d2s) ? 64'(nw) : 64'd0);
        if (acc) begin
            sumw = 0;
            for (int i = wq0; i < wait_q.size(); i++) sumw += wait_q[i];
            chk({nm, "_dram_reqs"}, 64'(wait_q.size() - wq0), 64'(nw));
            e_exp = (exp_edges >= 0) ? exp_edges : 1 + nw * (d2s ? 2 : 3) + sumw;
            chk({nm, "_edges"}, 64'(edges), 64'(e_exp));
            chk({nm, "_dre_cycles"}, 64'(dre_cyc - dre0), d2s ? 64'(nw + sumw) : 64'd0);
            chk({nm, "_dwe_cycles"}, 64'(dwe_cyc - dwe0), d2s ? 64'd0 : 64'(nw + sumw));
            for (int i = 0; i < nw; i++) begin
                if (d2s && (sw0 + i < sw_a.size())) begin
                    chk({nm, "_sw_addr"}, 64'(sw_a[sw0 + i]),
                        64'((d + 32'(4 * i)) & 32'h0000_3FFF));
                    chk({nm, "_sw_data"}, 64'(sw_d[sw0 + i]), 64'(dram_val(s + 32'(4 * i))));
                end else if (!d2s && (dw0 + i < dw_a.size())) begin
                    chk({nm, "_dw_addr"}, 64'(dw_a[dw0 + i]), 64'(d + 32'(4 * i)));
                    chk({nm, "_dw_data"}, 64'(dw_d[dw0 + i]), 64'(sram_peek(s + 32'(4 * i))));
                end
            end
        end else begin
            chk({nm, "_no_strobes"}, 64'((dre_cyc - dre0) + (dwe_cyc - dwe0)), 64'd0);
        end
    endtask

    typedef struct {
        string            nm;
        logic [1:0]       c;
        logic [31:0]      s;
        logic [31:0]      d;
        logic [LEN_W-1:0] n;
        int unsigned      w;
        int               exp_edges;
    } vec_t;

    vec_t vecs[7];
    int   sw0_r, vc0_r;

    initial begin
        vecs[0] = '{"basic_d2s", 2'b01, 32'h0000_1000, 32'h0000_0040, 10'd3, 0, 7};
        vecs[1] = '{"zero_len",  2'b01, 32'h0000_5000, 32'h0000_0080, 10'd0, 0, 1};
        vecs[2] = '{"s2d_wait",  2'b10, 32'h0000_3FFC, 32'h0000_8000, 10'd2, 3, 13};
        vecs[3] = '{"d2s_wrap",  2'b01, 32'hFFFF_FFFC, 32'h0000_3FF8, 10'd3, 2, 13};
        vecs[4] = '{"rsvd_cmd",  2'b11, 32'h0000_1000, 32'h0000_0040, 10'd2, 0, 0};
        vecs[5] = '{"none_cmd",  2'b00, 32'h0000_1000, 32'h0000_0040, 10'd2, 0, 0};
        vecs[6] = '{"s2d_fast",  2'b10, 32'h0000_0100, 32'hFFFF_FFFC, 10'd2, 0, 7};

        reset = 1'b1; cmd = 2'b00; srcAddr = '0; destAddr = '0; len = '0;
        stray = 1'b0; rand_wait = 1'b0; fixed_wait = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_enables", 64'({sramWriteEnable, dramReadEnable, dramWriteEnable}), 64'd0);
        chk("reset_stall_valid", 64'({stall, dmaValid}), 64'd0);
        chk("reset_addr", 64'({sramAddress, dramAddress}), 64'd0);
        chk("reset_wdata", 64'({sramWriteData, dramWriteData}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            xfer(vecs[i].nm, vecs[i].c, vecs[i].s, vecs[i].d, vecs[i].n, 1'b0,
                 vecs[i].w, 2'b00, vecs[i].exp_edges);

        // Reset during the third D2S read of a 4-word transfer.
        sw0_r = sw_a.size(); vc0_r = valid_cnt;
        rand_wait = 1'b0; fixed_wait = 0;
        @(negedge clk);
        cmd = 2'b01; srcAddr = 32'h0000_2000; destAddr = 32'h0000_0100; len = 10'd4;
        @(negedge clk);
        cmd = 2'b00;
        repeat (4) @(negedge clk);
        chk("rst_mid_rd_active", 64'(dramReadEnable), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_strobes", 64'({sramWriteEnable, dramReadEnable, dramWriteEnable, stall, dmaValid}), 64'd0);
        chk("rst_mid_addr", 64'(dramAddress), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid_no_valid", 64'(valid_cnt - vc0_r), 64'd0);
        chk("rst_mid_sram_writes", 64'(sw_a.size() - sw0_r), 64'd2);
        xfer("after_reset", 2'b01, 32'h0000_2000, 32'h0000_0100, 10'd4, 1'b0, 0, 2'b00, 9);

        // S2D command pulsed while a D2S is busy must be ignored.
        xfer("busy_cmd", 2'b01, 32'h0000_3000, 32'h0000_0200, 10'd2, 1'b0, 0, 2'b10, 5);

        for (int k = 0; k < 30; k++) begin
            int unsigned r;
            logic [1:0]  c;
            r = $urandom_range(0, 9);
            c = (r < 5) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11);
            xfer($sformatf("rand%0d", k), c, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 LEN_W'($urandom_range(0, 6)), 1'b1, 0, 2'b00, -1);
        end

        chk("no_enable_overlap", 64'(overlap_cnt), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
